transmissor_morse: RTL
======================

TRANSMISSOR_MORSE -- requirements
Module: transmissor_morse

Interface
REQ-001 SHALL have parameter: UNIT_CYCLES, 4, clock cycles per Morse time unit (legal range 1..255).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: ready  input  1  request to send the code on m.
REQ-005 SHALL have port: m  input  5  Morse code from the encoder; m[4]=m1 sent first, 1=dash, 0=dot.
REQ-006 SHALL have port: ack  output  1  combinational, high in the cycle a request is accepted.
REQ-007 SHALL have port: key  output  1  registered, high while tone is on.
REQ-008 SHALL have port: busy  output  1  registered, high from the cycle after acceptance until return to IDLE.
REQ-009 SHALL have port: done  output  1  registered, one-cycle pulse after a code's final gap completes.

Function
REQ-010 SHALL implement states IDLE, MARK, SPACE, GAP.
REQ-011 SHALL accept a request (ack=1) when ready=1 and state=IDLE, capturing m into a 5-bit shift register and a symbol index of 0.
REQ-012 SHALL enter MARK on the edge of acceptance: key=1 from the next cycle.
REQ-013 SHALL hold MARK for 1 unit (dot) or 3 units (dash), where 1 unit = UNIT_CYCLES cycles.
REQ-014 SHALL, after MARK, go to SPACE (key=0, 1 unit) if symbol index<4; otherwise go to GAP (key=0, 3 units).
REQ-015 SHALL, after SPACE, increment the symbol index, shift the code, and return to MARK.
REQ-016 SHALL, after GAP, return to IDLE with done=1 for exactly the first IDLE cycle.
REQ-017 SHALL accept a request in the cycle done=1; busy=0 in that cycle.
REQ-018 SHALL ignore ready while busy, with ack=0 and no effect on the captured code.
REQ-019 SHALL give each code a total duration of (dots+3*dashes)+4+3 units: 12 units for 00000 and 22 units for 11111.
REQ-020 SHALL use an 8-bit prescaler that wraps at UNIT_CYCLES-1 and a 2-bit unit counter; neither counter shall wrap mid-state.
REQ-021 SHALL sample m only on acceptance; changes to m while busy have no effect.
REQ-022 SHALL, with ready held high continuously, send the code back-to-back, each separated by the GAP plus one IDLE cycle.

Reset
REQ-023 SHALL, on reset=0 (asynchronous), immediately force state=IDLE, key=0, busy=0, done=0, counters=0, shift register=0, and buffer empty.
REQ-024 SHALL abandon any code in progress on reset mid-operation, with no done pulse.
REQ-025 SHALL accept a request in the first clock edge after reset deasserts.

Configuration
REQ-026 SHALL gate a one-entry request buffer with the macro TRANSMISSOR_BUFFER_EN.
REQ-027 SHALL, with TRANSMISSOR_BUFFER_EN defined, also accept when busy and the buffer is empty: ack=1 and m is stored in the buffer.
REQ-028 SHALL, with TRANSMISSOR_BUFFER_EN defined and the buffer full at GAP end, go directly to MARK with the buffered code: done=1 in that cycle, busy stays 1, buffer empties.
REQ-029 SHALL, without TRANSMISSOR_BUFFER_EN, have no buffer storage; behaviour is per REQ-018.

Structure
REQ-030 SHALL place the state encoding typedef (IDLE=0, MARK=1, SPACE=2, GAP=3), DOT_UNITS=1, DASH_UNITS=3, SPACE_UNITS=1, GAP_UNITS=3 and SYMBOLS=5 in shared package morse_pkg.
REQ-031 SHALL implement the prescaler as sub-module gerador_unidade (outputs a one-cycle tick per unit, cleared on state change).

Verification
REQ-032 SHALL verify: UNIT_CYCLES=4, m=11111, ready pulse at cycle 0 -> key high cycles 1-12, 17-28, 33-44, 49-60, 65-76; low 77-88; done=1 at cycle 89 only.
REQ-033 SHALL verify: UNIT_CYCLES=1, m=00000 -> key=1 on odd cycles 1-9, 0 on 10-12, done at cycle 13, busy high cycles 1-12.
REQ-034 SHALL verify: m=01111, then ready with m=10000 at cycle 5 (no buffer) -> ack=0 at cycle 5; only 01111 sent (first mark 4 cycles, then 12-cycle marks).
REQ-035 SHALL verify: reset=0 at cycle 6 during the first MARK -> key=0, busy=0 in the same cycle; no done; new code accepted after release.
REQ-036 SHALL verify: TRANSMISSOR_BUFFER_EN, UNIT_CYCLES=1, m=00000 then m=11111 at cycle 3 -> ack=1 at cycle 3; done=1 at cycle 13 with key=1 at cycle 13; busy continuously high.
REQ-037 SHALL verify: ready held high, UNIT_CYCLES=1, m=00000 -> done pulses at cycles 13 and 26 with no missed acceptance.

Source files
------------

// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse transmitter (transmissor_morse) and its
// unit prescaler (gerador_unidade).
//
// Contents:
//   state_t       2-bit FSM state type
//   IDLE..GAP     FSM state encodings (IDLE=0, MARK=1, SPACE=2, GAP=3)
//   *_UNITS       durations, in Morse time units, of each keyed interval
//   SYMBOLS       number of symbols in one code word (m[4] first)
//   last_unit()   helper that turns a duration into the final unit index
// -----------------------------------------------------------------------------
package morse_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t MARK  = 2'd1;
   localparam state_t SPACE = 2'd2;
   localparam state_t GAP   = 2'd3;

   localparam int DOT_UNITS   = 1;
   localparam int DASH_UNITS  = 3;
   localparam int SPACE_UNITS = 1;
   localparam int GAP_UNITS   = 3;
   localparam int SYMBOLS     = 5;

   // The unit counter runs 0..units-1, so a state ends on the tick seen
   // while the counter holds units-1.
   function automatic logic [1:0] last_unit(input int units);
      return 2'(units - 1);
   endfunction

endpackage

// File: rtl/transmissor_morse_gerador_unidade.sv
// -----------------------------------------------------------------------------
// gerador_unidade
// Prescaler that divides the clock into Morse time units. An 8-bit counter
// runs 0..UNIT_CYCLES-1 and raises tick for one cycle at the last count, then
// wraps. Asserting clear restarts the count so a new state always gets a full
// unit before its first tick.
//
// Parameters:
//   UNIT_CYCLES  clock cycles per unit (1..255)
// Ports:
//   clk    input   clock, rising edge
//   reset  input   asynchronous active-low reset
//   clear  input   restart the count from zero on the next edge
//   tick   output  one-cycle pulse at the last cycle of each unit
// -----------------------------------------------------------------------------
module gerador_unidade #(
   parameter int UNIT_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam logic [7:0] LAST_COUNT = 8'(UNIT_CYCLES - 1);

   logic [7:0] count_reg;

   // tick deliberately does not depend on clear: clear is derived from the
   // FSM next-state, which itself depends on tick.
   assign tick = (count_reg == LAST_COUNT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (clear || tick) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + 8'd1;
      end
   end

endmodule

// File: rtl/transmissor_morse.sv
// -----------------------------------------------------------------------------
// transmissor_morse
// Keys out a 5-symbol Morse code word. m[4] is sent first; 1 = dash (3 units
// of tone), 0 = dot (1 unit). Symbols are separated by a 1-unit space and the
// word ends with a 3-unit gap, after which done pulses for one cycle.
//
// Optional feature (macro TRANSMISSOR_BUFFER_EN): a one-entry request buffer
// lets a second word be accepted while busy; it is started straight from the
// end of the current gap without passing through IDLE.
//
// Parameters:
//   UNIT_CYCLES  clock cycles per Morse unit (1..255)
// Ports:
//   clk    input        clock, rising edge
//   reset  input        asynchronous active-low reset
//   ready  input        request to send the code on m
//   m      input [4:0]  code word, m[4] sent first
//   ack    output       combinational, high in the cycle a request is taken
//   key    output       registered, high while the tone is on
//   busy   output       registered, high while a word is being sent
//   done   output       registered, one-cycle pulse after the final gap
// -----------------------------------------------------------------------------
module transmissor_morse
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ready,
   input  logic [4:0] m,
   output logic       ack,
   output logic       key,
   output logic       busy,
   output logic       done
);

   state_t     state_reg, state_next;
   logic [4:0] shift_reg, shift_next;
   logic [2:0] idx_reg, idx_next;
   logic [1:0] unit_reg, unit_next;
   logic       key_reg, busy_reg, done_reg;
   logic       done_next;

   logic       tick;
   logic       prescaler_clear;
   logic [1:0] unit_last;
   logic       state_end;
   logic       accept_idle;
   logic       accept_buf;

`ifdef TRANSMISSOR_BUFFER_EN
   logic       buf_valid_reg, buf_valid_next;
   logic [4:0] buf_code_reg, buf_code_next;
`endif

   // ---------------------------------------------------------------------
   // Unit prescaler. Held cleared in IDLE and restarted on every state
   // change so each interval is an exact multiple of UNIT_CYCLES.
   // ---------------------------------------------------------------------
   gerador_unidade #(
      .UNIT_CYCLES(UNIT_CYCLES)
   ) u_gerador_unidade (
      .clk  (clk),
      .reset(reset),
      .clear(prescaler_clear),
      .tick (tick)
   );

   assign prescaler_clear = (state_reg == IDLE) || (state_next != state_reg);

   // ---------------------------------------------------------------------
   // Request acceptance
   // ---------------------------------------------------------------------
   assign accept_idle = ready && (state_reg == IDLE);

`ifdef TRANSMISSOR_BUFFER_EN
   assign accept_buf = ready && (state_reg != IDLE) && !buf_valid_reg;
`else
   assign accept_buf = 1'b0;
`endif

   assign ack = accept_idle || accept_buf;

   // ---------------------------------------------------------------------
   // Duration of the current state, as the index of its final unit
   // ---------------------------------------------------------------------
   always_comb begin
      unit_last = 2'd0;
      case (state_reg)
         MARK:    unit_last = shift_reg[4] ? last_unit(DASH_UNITS)
                                           : last_unit(DOT_UNITS);
         SPACE:   unit_last = last_unit(SPACE_UNITS);
         GAP:     unit_last = last_unit(GAP_UNITS);
         default: unit_last = 2'd0;
      endcase
   end

   assign state_end = tick && (unit_reg == unit_last);

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      idx_next   = idx_reg;
      done_next  = 1'b0;
`ifdef TRANSMISSOR_BUFFER_EN
      buf_valid_next = buf_valid_reg;
      buf_code_next  = buf_code_reg;
      if (accept_buf) begin
         buf_valid_next = 1'b1;
         buf_code_next  = m;
      end
`endif

      case (state_reg)
         IDLE: begin
            if (accept_idle) begin
               state_next = MARK;
               shift_next = m;
               idx_next   = 3'd0;
            end
         end

         MARK: begin
            if (state_end) begin
               // The last symbol is followed by the word gap instead of
               // the inter-symbol space.
               if (idx_reg < 3'(SYMBOLS - 1)) begin
                  state_next = SPACE;
               end else begin
                  state_next = GAP;
               end
            end
         end

         SPACE: begin
            if (state_end) begin
               state_next = MARK;
               idx_next   = idx_reg + 3'd1;
               shift_next = {shift_reg[3:0], 1'b0};
            end
         end

         GAP: begin
            if (state_end) begin
               done_next  = 1'b1;
               state_next = IDLE;
`ifdef TRANSMISSOR_BUFFER_EN
               // Chain straight into the next word. A request arriving in
               // this very cycle (buffer empty) is started directly rather
               // than parked in the buffer.
               if (buf_valid_reg) begin
                  state_next     = MARK;
                  shift_next     = buf_code_reg;
                  idx_next       = 3'd0;
                  buf_valid_next = 1'b0;
               end else if (accept_buf) begin
                  state_next     = MARK;
                  shift_next     = m;
                  idx_next       = 3'd0;
                  buf_valid_next = 1'b0;
               end
`endif
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Unit counter: restarts on every state change, so it never wraps in
   // the middle of a state (largest index used is DASH/GAP = 2).
   always_comb begin
      unit_next = unit_reg;
      if ((state_reg == IDLE) || (state_next != state_reg)) begin
         unit_next = 2'd0;
      end else if (tick) begin
         unit_next = unit_reg + 2'd1;
      end
   end

   // ---------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         idx_reg   <= '0;
         unit_reg  <= '0;
         key_reg   <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         idx_reg   <= idx_next;
         unit_reg  <= unit_next;
         key_reg   <= (state_next == MARK);
         busy_reg  <= (state_next != IDLE);
         done_reg  <= done_next;
      end
   end

`ifdef TRANSMISSOR_BUFFER_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_valid_reg <= 1'b0;
         buf_code_reg  <= '0;
      end else begin
         buf_valid_reg <= buf_valid_next;
         buf_code_reg  <= buf_code_next;
      end
   end
`endif

   assign key  = key_reg;
   assign busy = busy_reg;
   assign done = done_reg;

endmodule
